// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA timing generator with a latency-compensated pixel request
//   interface. A request stage issues pixel coordinates to the display logic.
//   Sync, blanking and colour are re-aligned so that all four reach the DAC on
//   the same clock edge, DATA_LAT+1 cycles after the request.
//
// Optional feature (compile-time macro VGA_TG_TESTPAT_EN):
//   Adds input test_en. While it is high, vga_rgb shows 8 vertical colour bars
//   instead of pixel_data.
//
// Ports
//   vga_clk      in   1   pixel clock, rising edge
//   sys_rst      in   1   synchronous active-high reset
//   pixel_data   in   24  RGB from display logic, DATA_LAT cycles after request
//   test_en      in   1   colour-bar select (VGA_TG_TESTPAT_EN builds only)
//   pixel_req    out  1   current request addresses a visible pixel
//   pixel_xpos   out  CW  requested column (0 when not requesting)
//   pixel_ypos   out  CW  requested row (0 when not requesting)
//   line_start   out  1   pulse at h=0 (request timeline)
//   frame_start  out  1   pulse at h=0, v=0 (request timeline)
//   frame_cnt    out  16  frames started since reset
//   vga_hs/vs    out  1   DAC-aligned syncs
//   vga_de       out  1   DAC-aligned data enable
//   vga_rgb      out  24  DAC colour, 0 while vga_de is low
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int DATA_LAT = 1,
  parameter int CW       = 11
) (
  input  logic          vga_clk,
  input  logic          sys_rst,
  input  logic [23:0]   pixel_data,
`ifdef VGA_TG_TESTPAT_EN
  input  logic          test_en,
`endif
  output logic          pixel_req,
  output logic [CW-1:0] pixel_xpos,
  output logic [CW-1:0] pixel_ypos,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [23:0]   vga_rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Alignment shift register depth; one dummy stage keeps the vector legal
  // when DATA_LAT is 0 (the tap then bypasses it).
  localparam int SRW = (DATA_LAT > 0) ? DATA_LAT : 1;

  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

  // The counters hold the position of the NEXT request; the request stage
  // registers them, so the first cycle after reset presents (0,0).
  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] v_cnt_r;
  logic          vis_s;
  logic          hs_act_r;
  logic          vs_act_r;
  logic [SRW-1:0] de_sr_r;
  logic [SRW-1:0] hs_sr_r;
  logic [SRW-1:0] vs_sr_r;
  logic          de_tap_s;
  logic          hs_tap_s;
  logic          vs_tap_s;
  logic [23:0]   rgb_next_s;

`ifdef VGA_TG_TESTPAT_EN
  localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
  logic [CW-1:0] x_sr_r [SRW];
  logic [CW-1:0] x_tap_s;
  logic [CW-1:0] bar_q_s;
  logic [2:0]    bar_idx_s;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction
`endif

  // Horizontal / vertical position counters
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      h_cnt_r <= {CW{1'b0}};
      v_cnt_r <= {CW{1'b0}};
    end else if (h_cnt_r == H_LAST) begin
      h_cnt_r <= {CW{1'b0}};
      if (v_cnt_r == V_LAST) begin
        v_cnt_r <= {CW{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + CW'(1);
      end
    end else begin
      h_cnt_r <= h_cnt_r + CW'(1);
    end
  end

  // Visible-area decode of the counter position
  always_comb begin
    vis_s = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
  end

  // Request stage: coordinates, strobes and raw sync flags
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      pixel_req   <= 1'b0;
      pixel_xpos  <= {CW{1'b0}};
      pixel_ypos  <= {CW{1'b0}};
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_act_r    <= 1'b0;
      vs_act_r    <= 1'b0;
    end else begin
      pixel_req   <= vis_s;
      pixel_xpos  <= vis_s ? h_cnt_r : {CW{1'b0}};
      pixel_ypos  <= vis_s ? v_cnt_r : {CW{1'b0}};
      line_start  <= (h_cnt_r == {CW{1'b0}});
      frame_start <= (h_cnt_r == {CW{1'b0}}) && (v_cnt_r == {CW{1'b0}});
      hs_act_r    <= (h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END);
      vs_act_r    <= (v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END);
    end
  end

  // Frame counter, advanced in the cycle after each frame_start
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      frame_cnt <= 16'h0000;
    end else if (frame_start) begin
      frame_cnt <= frame_cnt + 16'h0001;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // Latency-matching shift register for de/hs/vs (stage 0 = request + 1)
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      de_sr_r <= {SRW{1'b0}};
      hs_sr_r <= {SRW{1'b0}};
      vs_sr_r <= {SRW{1'b0}};
    end else begin
      de_sr_r[0] <= pixel_req;
      hs_sr_r[0] <= hs_act_r;
      vs_sr_r[0] <= vs_act_r;
      for (int i = 1; i < SRW; i++) begin
        de_sr_r[i] <= de_sr_r[i-1];
        hs_sr_r[i] <= hs_sr_r[i-1];
        vs_sr_r[i] <= vs_sr_r[i-1];
      end
    end
  end

`ifdef VGA_TG_TESTPAT_EN
  // Delayed x position so the bars line up with vga_de
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < SRW; i++) begin
        x_sr_r[i] <= {CW{1'b0}};
      end
    end else begin
      x_sr_r[0] <= pixel_xpos;
      for (int i = 1; i < SRW; i++) begin
        x_sr_r[i] <= x_sr_r[i-1];
      end
    end
  end
`endif

  // Taps: the request-stage value delayed by exactly DATA_LAT cycles
  always_comb begin
    if (DATA_LAT == 0) begin
      de_tap_s = pixel_req;
      hs_tap_s = hs_act_r;
      vs_tap_s = vs_act_r;
    end else begin
      de_tap_s = de_sr_r[SRW-1];
      hs_tap_s = hs_sr_r[SRW-1];
      vs_tap_s = vs_sr_r[SRW-1];
    end
  end

`ifdef VGA_TG_TESTPAT_EN
  // Colour-bar index from the delayed column, clamped to the last bar
  always_comb begin
    if (DATA_LAT == 0) begin
      x_tap_s = pixel_xpos;
    end else begin
      x_tap_s = x_sr_r[SRW-1];
    end
    bar_q_s   = x_tap_s / BAR_W;
    bar_idx_s = (bar_q_s > CW'(7)) ? 3'd7 : bar_q_s[2:0];
  end
`endif

  // Colour select: blanked outside the visible area
  always_comb begin
    rgb_next_s = 24'h000000;
    if (de_tap_s) begin
`ifdef VGA_TG_TESTPAT_EN
      if (test_en) begin
        rgb_next_s = bar_color(bar_idx_s);
      end else begin
        rgb_next_s = pixel_data;
      end
`else
      rgb_next_s = pixel_data;
`endif
    end else begin
      rgb_next_s = 24'h000000;
    end
  end

  // DAC-aligned output registers
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      vga_de  <= 1'b0;
      vga_hs  <= ~HS_POL;
      vga_vs  <= ~VS_POL;
      vga_rgb <= 24'h000000;
    end else begin
      vga_de  <= de_tap_s;
      vga_hs  <= hs_tap_s ? HS_POL : ~HS_POL;
      vga_vs  <= vs_tap_s ? VS_POL : ~VS_POL;
      vga_rgb <= rgb_next_s;
    end
  end

endmodule
